oam_dma_arbiter: RTL and testbench
==================================

Name: oam_dma_arbiter

Overview:
- Owns the single CPU memory bus and shares it between the cpu core and the sprite (OAM) DMA engine.
- A CPU write to the DMA register starts DMA. The block then halts the cpu via cpu_rdy and drives 256 read/write pairs: source page → PPU OAM data port.
- Sits between cpu and the system address decoder. All external memory/PPU traffic passes through it.

Parameters:
- DMA_REG_ADDR, 16'h4014, CPU address that triggers DMA; write data is the source page.
- OAM_DATA_ADDR, 16'h2004, destination address for every DMA write.

Ports:
- clk  in  1  system clock, one CPU cycle per edge
- rst  in  1  asynchronous, active-low reset
- cpu_addr  in  16  address from cpu core
- cpu_d_out  in  8  write data from cpu core
- cpu_we  in  1  cpu write strobe
- cpu_d_in  out  8  read data returned to cpu (equals bus_d_in)
- cpu_rdy  out  1  1 = cpu may advance; 0 = cpu holds state
- bus_addr  out  16  system address bus
- bus_d_out  out  8  system write data
- bus_we  out  1  system write strobe
- bus_d_in  in  8  system read data
- dma_busy  out  1  high from the first HALT cycle through the last WRITE cycle

Behaviour:
- Reset (rst low, async):
  - state=IDLE, page=0, idx=0, latch=0, parity=0.
  - cpu_rdy=1, dma_busy=0, bus_we follows cpu_we.
- parity: 1-bit toggle every clk since reset (0 = get cycle, 1 = put cycle). It runs freely in all states.
- IDLE:
  - Bus is transparent: bus_addr=cpu_addr, bus_d_out=cpu_d_out, bus_we=cpu_we.
  - Trigger: cpu_we=1 and cpu_addr==DMA_REG_ADDR at a clk edge. The write also reaches the bus.
  - On trigger: page<=cpu_d_out, idx<=0, next state HALT.
- HALT (1 cycle):
  - cpu_rdy=0, dma_busy=1.
  - bus_addr=cpu_addr, bus_we forced 0.
  - Next state ALIGN if parity==0 this cycle, else READ. This makes the first READ land on a get cycle.
- ALIGN (0 or 1 cycle):
  - cpu_rdy=0, bus_we=0, bus_addr=cpu_addr.
  - Next state READ.
- READ:
  - bus_addr={page,idx}, bus_we=0.
  - latch<=bus_d_in at the edge.
  - Next state WRITE.
- WRITE:
  - bus_addr=OAM_DATA_ADDR, bus_d_out=latch, bus_we=1.
  - At the edge: idx<=idx+1 (8-bit, wraps).
  - If idx==8'hFF this cycle, next state IDLE; else READ.
- Length: trigger to cpu_rdy=1 is exactly 513 cycles (parity 1 at HALT) or 514 (parity 0 at HALT).
  - cpu_rdy returns to 1 in the first cycle after the last WRITE.
- Halted cpu writes:
  - While state≠IDLE, cpu_we/cpu_addr never reach the bus.
  - A DMA_REG_ADDR write seen while busy is ignored and does not restart DMA.
- Page FF: reads 16'hFF00..16'hFFFF. idx wrap does not carry into page.
- cpu_d_in=bus_d_in at all times. cpu must not sample while cpu_rdy=0.
- Reset mid-DMA: immediate return to IDLE with all reset values. No partial-transfer completion.

Decomposition:
- Shared package nes_pkg:
  - dma_state_t enum {IDLE, HALT, ALIGN, READ, WRITE}
  - DMA_REG_ADDR and OAM_DATA_ADDR constants
- Single module. The bus mux and FSM are small enough that no sub-module is warranted.

Test Plan:
- Transparent: IDLE, cpu_addr=16'h0200, cpu_we=1, cpu_d_out=8'h5A → bus_addr=16'h0200, bus_we=1, bus_d_out=8'h5A, cpu_rdy=1.
- Trigger, even alignment: write 8'h02 to 16'h4014 with parity 0 at HALT → one ALIGN cycle, then reads 16'h0200..16'h02FF. Each is followed by a write to 16'h2004 of the model memory byte. cpu_rdy low for exactly 514 cycles.
- Odd alignment: same trigger shifted one cycle → no ALIGN, cpu_rdy low for exactly 513 cycles. First READ occurs on parity 0.
- Page wrap: page 8'hFF, memory[16'hFFFF]=8'hC3 → last READ addr 16'hFFFF, last WRITE data 8'hC3. Next cycle state IDLE, dma_busy=0.
- Halted writes blocked: during DMA cpu drives cpu_we=1, addr 16'h4014, data 8'h07 → bus_we only on WRITE cycles to 16'h2004. No restart, page stays unchanged.
- Reset mid-DMA: assert rst low at idx=8'h40 → cpu_rdy=1, dma_busy=0, bus transparent asynchronously. Later trigger with 8'h03 restarts at 16'h0300.

Source files
------------

// File: rtl/nes_pkg.sv
// Purpose: shared types and fixed addresses for the CPU-bus / sprite DMA logic.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package nes_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HALT,
        ALIGN,
        READ,
        WRITE
    } dma_state_t;

    // A CPU write to this address starts DMA; the write data is the source page.
    localparam logic [15:0] DMA_REG_ADDR  = 16'h4014;
    // PPU OAM data port: destination of every DMA write.
    localparam logic [15:0] OAM_DATA_ADDR = 16'h2004;

endpackage

// File: rtl/oam_dma_arbiter.sv
// Purpose: owns the CPU memory bus, shares it between the cpu core and the sprite DMA engine.
// Latency: bus is combinationally transparent in IDLE; a DMA holds the cpu for 513 or 514 cycles.
// Backpressure: cpu_rdy=0 halts the cpu from HALT through the last WRITE; its bus traffic is dropped.
//
// Ports:
//   clk, rst                    clock (one CPU cycle per edge), async active-low reset
//   cpu_addr/cpu_d_out/cpu_we   cpu-side request
//   cpu_d_in, cpu_rdy           read data to cpu (always bus_d_in), cpu advance enable
//   bus_addr/bus_d_out/bus_we   system bus request
//   bus_d_in                    system read data
//   dma_busy                    high from HALT through the last WRITE
module oam_dma_arbiter
    import nes_pkg::*;
#(
    parameter logic [15:0] DMA_REG = DMA_REG_ADDR,
    parameter logic [15:0] OAM_REG = OAM_DATA_ADDR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_d_out,
    input  logic        cpu_we,
    output logic [7:0]  cpu_d_in,
    output logic        cpu_rdy,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_d_out,
    output logic        bus_we,
    input  logic [7:0]  bus_d_in,
    output logic        dma_busy
);

    dma_state_t state;
    logic [7:0] page;
    logic [7:0] idx;
    logic [7:0] latch;
    // 0 = get cycle, 1 = put cycle; free-running so DMA reads can be aligned to get cycles.
    logic       parity;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            page   <= 8'h00;
            idx    <= 8'h00;
            latch  <= 8'h00;
            parity <= 1'b0;
        end else begin
            parity <= ~parity;
            case (state)
                IDLE: begin
                    if (cpu_we && (cpu_addr == DMA_REG)) begin
                        page  <= cpu_d_out;
                        idx   <= 8'h00;
                        state <= HALT;
                    end
                end
                // An extra ALIGN cycle is inserted when HALT falls on a get cycle,
                // so the first READ always lands on a get cycle.
                HALT:    state <= parity ? READ : ALIGN;
                ALIGN:   state <= READ;
                READ: begin
                    latch <= bus_d_in;
                    state <= WRITE;
                end
                WRITE: begin
                    idx   <= idx + 8'd1;
                    state <= (idx == 8'hFF) ? IDLE : READ;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs decode the registered state; while not IDLE the cpu strobe never reaches the bus.
    always_comb begin
        cpu_d_in  = bus_d_in;
        cpu_rdy   = 1'b0;
        dma_busy  = 1'b1;
        bus_addr  = cpu_addr;
        bus_d_out = latch;
        bus_we    = 1'b0;
        case (state)
            IDLE: begin
                cpu_rdy   = 1'b1;
                dma_busy  = 1'b0;
                bus_d_out = cpu_d_out;
                bus_we    = cpu_we;
            end
            READ:  bus_addr = {page, idx};
            WRITE: begin
                bus_addr = OAM_REG;
                bus_we   = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Purpose: directed self-checking bench for oam_dma_arbiter with a combinational memory model.
// Latency: inputs change 1 ns after the rising edge, outputs are sampled on the falling edge.
// Backpressure: n/a.
module tb_oam_dma_arbiter;

    logic        clk;
    logic        rst;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_d_out;
    logic        cpu_we;
    logic [7:0]  cpu_d_in;
    logic        cpu_rdy;
    logic [15:0] bus_addr;
    logic [7:0]  bus_d_out;
    logic        bus_we;
    logic [7:0]  bus_d_in;
    logic        dma_busy;

    int errors = 0;
    int checks = 0;
    logic tb_par;

    oam_dma_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_addr  (cpu_addr),
        .cpu_d_out (cpu_d_out),
        .cpu_we    (cpu_we),
        .cpu_d_in  (cpu_d_in),
        .cpu_rdy   (cpu_rdy),
        .bus_addr  (bus_addr),
        .bus_d_out (bus_d_out),
        .bus_we    (bus_we),
        .bus_d_in  (bus_d_in),
        .dma_busy  (dma_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents as a pure function of address; FFFF holds the page-wrap marker.
    function automatic logic [7:0] mem_f(input logic [15:0] a);
        if (a == 16'hFFFF) return 8'hC3;
        return a[7:0] ^ a[15:8] ^ 8'hA5;
    endfunction

    assign bus_d_in = mem_f(bus_addr);

    // Reference get/put phase: toggles every edge since reset.
    always @(posedge clk or negedge rst) begin
        if (!rst) tb_par <= 1'b0;
        else      tb_par <= ~tb_par;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic [15:0] a, input logic [7:0] d, input logic we);
        @(posedge clk);
        #1;
        cpu_addr  = a;
        cpu_d_out = d;
        cpu_we    = we;
        @(negedge clk);
    endtask

    // Runs one DMA of page pg. want_align selects a HALT on a get cycle (one ALIGN cycle).
    // blk drives a DMA-register write from the halted cpu. abort >= 0 resets at that READ index.
    task automatic do_dma(input logic [7:0] pg, input bit want_align, input bit blk, input int abort);
        logic [15:0] ha;
        logic [7:0]  hd;
        logic        hw;
        logic [7:0]  ib;
        int          low;
        ha = blk ? 16'h4014 : 16'h1234;
        hd = blk ? 8'h07 : 8'h00;
        hw = blk;
        low = 0;
        // Trigger-cycle parity must be 1 for ALIGN (HALT then sits on parity 0).
        if (tb_par == want_align) cyc(16'h0000, 8'h00, 1'b0);
        cyc(16'h4014, pg, 1'b1);
        chk("trig_par", tb_par, want_align);
        chk("trig_bus_we", bus_we, 1);
        chk("trig_bus_addr", bus_addr, 16'h4014);
        chk("trig_bus_dout", bus_d_out, pg);
        chk("trig_rdy", cpu_rdy, 1);
        cyc(ha, hd, hw);
        chk("halt_rdy", cpu_rdy, 0);
        chk("halt_busy", dma_busy, 1);
        chk("halt_we", bus_we, 0);
        chk("halt_addr", bus_addr, ha);
        low++;
        if (want_align) begin
            cyc(ha, hd, hw);
            chk("align_rdy", cpu_rdy, 0);
            chk("align_we", bus_we, 0);
            chk("align_addr", bus_addr, ha);
            low++;
        end
        for (int i = 0; i < 256; i++) begin
            ib = i[7:0];
            cyc(ha, hd, hw);
            if (abort == i) begin
                #2 rst = 1'b0;
                #1;
                chk("rst_rdy", cpu_rdy, 1);
                chk("rst_busy", dma_busy, 0);
                chk("rst_addr", bus_addr, cpu_addr);
                chk("rst_we", bus_we, cpu_we);
                cpu_we = 1'b0;
                @(negedge clk);
                rst = 1'b1;
                return;
            end
            chk("rd_addr", bus_addr, {pg, ib});
            chk("rd_we", bus_we, 0);
            chk("rd_rdy", cpu_rdy, 0);
            chk("rd_par", tb_par, 0);
            chk("rd_din", cpu_d_in, mem_f({pg, ib}));
            low++;
            cyc(ha, hd, hw);
            chk("wr_addr", bus_addr, 16'h2004);
            chk("wr_we", bus_we, 1);
            chk("wr_dat", bus_d_out, mem_f({pg, ib}));
            chk("wr_busy", dma_busy, 1);
            low++;
        end
        cyc(16'h0300, 8'h11, 1'b0);
        chk("done_rdy", cpu_rdy, 1);
        chk("done_busy", dma_busy, 0);
        chk("done_addr", bus_addr, 16'h0300);
        chk("low_cycles", low, want_align ? 514 : 513);
        cyc(16'h0301, 8'h22, 1'b0);
        chk("stay_idle", dma_busy, 0);
    endtask

    initial begin
        rst       = 1'b0;
        cpu_addr  = 16'h0123;
        cpu_d_out = 8'h44;
        cpu_we    = 1'b1;
        #12;
        chk("reset_rdy", cpu_rdy, 1);
        chk("reset_busy", dma_busy, 0);
        chk("reset_we", bus_we, 1);
        chk("reset_addr", bus_addr, 16'h0123);
        cpu_we = 1'b0;
        #1;
        chk("reset_we0", bus_we, 0);
        @(negedge clk);
        rst = 1'b1;

        // Transparent IDLE write.
        cyc(16'h0200, 8'h5A, 1'b1);
        chk("tr_addr", bus_addr, 16'h0200);
        chk("tr_we", bus_we, 1);
        chk("tr_dout", bus_d_out, 8'h5A);
        chk("tr_rdy", cpu_rdy, 1);
        chk("tr_din", cpu_d_in, mem_f(16'h0200));

        do_dma(8'h02, 1'b1, 1'b0, -1);  // even alignment
        do_dma(8'h02, 1'b0, 1'b0, -1);  // odd alignment
        do_dma(8'hFF, 1'b0, 1'b0, -1);  // page FF, last byte C3
        do_dma(8'h05, 1'b1, 1'b1, -1);  // halted cpu writes to 4014 blocked
        do_dma(8'h04, 1'b0, 1'b0, 64);  // reset at idx 40
        chk("post_rst_busy", dma_busy, 0);
        do_dma(8'h03, 1'b0, 1'b0, -1);  // fresh DMA after reset

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
